// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths and FSM state encodings for the CORDIC sweep controller and core
package cordic_pkg;

    localparam int DW_ANGLE_DEF             = 7;
    localparam int DW_FRACTION_DEF          = 6;
    localparam int DW_CALCULATION_TERMS_DEF = 16;

    localparam int RW = DW_CALCULATION_TERMS_DEF + DW_FRACTION_DEF + 1;
    localparam int AW = DW_ANGLE_DEF + 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_ISSUE      = 3'd1;
    localparam state_t S_WAIT_READY = 3'd2;
    localparam state_t S_PRESENT    = 3'd3;
    localparam state_t S_RELEASE    = 3'd4;
    localparam state_t S_DONE       = 3'd5;

endpackage

// File: rtl/cordic_sweep_controller.sv
// rtl/cordic_sweep_controller.sv - steps a CORDIC responder through an angle sweep over a four-phase handshake
module cordic_sweep_controller
    import cordic_pkg::*;
#(
    parameter int DW_ANGLE             = DW_ANGLE_DEF,
    parameter int DW_FRACTION          = DW_FRACTION_DEF,
    parameter int DW_CALCULATION_TERMS = DW_CALCULATION_TERMS_DEF,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [DW_ANGLE:0]                         angle_start,
    input  logic [DW_ANGLE:0]                         angle_step,
    input  logic [DW_ANGLE:0]                         num_angles,
    input  logic [DW_CALCULATION_TERMS+DW_FRACTION:0] x_scale,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error,
    output logic                                      cordic_initiate,
    output logic [DW_ANGLE:0]                         cordic_angle,
    output logic [DW_CALCULATION_TERMS+DW_FRACTION:0] cordic_x_scale,
    output logic                                      cordic_ack,
    input  logic [DW_CALCULATION_TERMS+DW_FRACTION:0] cordic_result,
    input  logic                                      cordic_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DW_CALCULATION_TERMS+DW_FRACTION:0] out_data,
    output logic [DW_ANGLE:0]                         out_index
);

    localparam int A_W = DW_ANGLE + 1;
    localparam int R_W = DW_CALCULATION_TERMS + DW_FRACTION + 1;
    localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [A_W-1:0] A_ONE   = 1;
    localparam logic [T_W-1:0] T_ONE   = 1;
    localparam logic [T_W-1:0] T_LAST  = T_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [A_W-1:0]   r_angle;
    logic [A_W-1:0]   r_step;
    logic [A_W-1:0]   r_num;
    logic [A_W-1:0]   r_index;
    logic [R_W-1:0]   r_x_scale;
    logic [R_W-1:0]   r_data;
    logic [T_W-1:0]   r_cnt;
    logic             r_error;
    logic             r_initiate;

    logic             w_last;
    logic             w_expired;

    assign w_last    = (r_index == r_num - A_ONE);
    assign w_expired = (r_cnt == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_angle    <= '0;
            r_step     <= '0;
            r_num      <= '0;
            r_index    <= '0;
            r_x_scale  <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_error    <= 1'b0;
            r_initiate <= 1'b0;
        end else begin
            r_initiate <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (num_angles != '0) begin
                            r_angle   <= angle_start;
                            r_step    <= angle_step;
                            r_num     <= num_angles;
                            r_x_scale <= x_scale;
                            r_index   <= '0;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                // The request pulse is registered so it appears on the first WAIT_READY cycle.
                S_ISSUE: begin
                    r_initiate <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_WAIT_READY;
                end
                S_WAIT_READY: begin
                    if (cordic_ready) begin
                        r_data  <= cordic_result;
                        r_state <= S_PRESENT;
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + T_ONE;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!cordic_ready) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + A_ONE;
                            r_angle <= r_angle + r_step;
                            r_state <= S_ISSUE;
                        end
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + T_ONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done            = (r_state == S_DONE);
    assign error           = r_error;
    assign cordic_initiate = r_initiate;
    assign cordic_angle    = r_angle;
    assign cordic_x_scale  = r_x_scale;
    assign cordic_ack      = (r_state == S_RELEASE);
    assign out_valid       = (r_state == S_PRESENT);
    assign out_data        = r_data;
    assign out_index       = r_index;

endmodule

// File: tb/tb_cordic_sweep_controller.sv
// tb/tb_cordic_sweep_controller.sv - self-checking bench with a behavioural four-phase responder
module tb_cordic_sweep_controller;

    localparam int AWB = 8;
    localparam int RWB = 23;

    typedef struct {
        logic [RWB-1:0] data;
        logic [AWB-1:0] idx;
    } exp_t;

    typedef struct {
        logic [AWB-1:0] as;
        logic [AWB-1:0] st;
        logic [AWB-1:0] n;
        logic [RWB-1:0] sc;
        logic [AWB-1:0] last_angle;
    } vec_t;

    logic clk, rst, start;
    logic [AWB-1:0] angle_start, angle_step, num_angles;
    logic [RWB-1:0] x_scale;
    logic busy, done, error, cordic_initiate, cordic_ack;
    logic [AWB-1:0] cordic_angle, out_index;
    logic [RWB-1:0] cordic_x_scale, cordic_result, out_data;
    logic cordic_ready, out_valid, out_ready;

    cordic_sweep_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .angle_start(angle_start), .angle_step(angle_step), .num_angles(num_angles),
        .x_scale(x_scale), .busy(busy), .done(done), .error(error),
        .cordic_initiate(cordic_initiate), .cordic_angle(cordic_angle),
        .cordic_x_scale(cordic_x_scale), .cordic_ack(cordic_ack),
        .cordic_result(cordic_result), .cordic_ready(cordic_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_init = 0;
    int n_out = 0;
    logic [AWB-1:0] ang_q[$];
    exp_t           sb_q[$];

    bit resp_enable = 1;
    int resp_delay  = 0;
    int drop_delay  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Q6 cosine at the unity-sweep angles (degrees), otherwise an arbitrary mix.
    function automatic logic [RWB-1:0] model(input logic [AWB-1:0] a, input logic [RWB-1:0] s);
        logic [31:0] t;
        t = {9'd0, s};
        case (a)
            8'd0:    return s;
            8'd30:   return RWB'((t * 55) >> 6);
            8'd60:   return RWB'((t * 32) >> 6);
            8'd90:   return '0;
            default: return s ^ {15'd0, a};
        endcase
    endfunction

    // Responder: latches the request, raises ready after resp_delay, holds until ack, drops after drop_delay.
    initial begin
        int st, w;
        logic [AWB-1:0] ra;
        logic [RWB-1:0] rs;
        st = 0; w = 0; ra = '0; rs = '0;
        cordic_ready = 1'b0;
        cordic_result = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cordic_ready = 1'b0;
                st = 0;
            end else begin
                case (st)
                    0: if (cordic_initiate) begin
                        ra = cordic_angle; rs = cordic_x_scale; w = resp_delay;
                        st = resp_enable ? 1 : 0;
                    end
                    1: if (w == 0) begin
                        cordic_ready = 1'b1; cordic_result = model(ra, rs); st = 2;
                    end else w--;
                    2: if (cordic_ack) begin w = drop_delay; st = 3; end
                    3: if (w == 0) begin cordic_ready = 1'b0; st = 0; end else w--;
                    default: st = 0;
                endcase
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cordic_initiate) begin
                    n_init++;
                    chk("init_expected", ang_q.size() != 0, 1);
                    if (ang_q.size() != 0) chk("cordic_angle", cordic_angle, ang_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    chk("out_expected", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_index", out_index, e.idx);
                    end
                end
            end
        end
    end

    task automatic run_sweep(input logic [AWB-1:0] as, input logic [AWB-1:0] st,
                             input logic [AWB-1:0] n, input logic [RWB-1:0] sc, input bit push_all,
                             output int init_k, output int done_k, output int ninit, output int nout,
                             output logic err, output logic [AWB-1:0] ang_at_done, output logic after);
        int i0, o0;
        logic [AWB-1:0] a;
        exp_t e;
        a = as;
        for (int k = 0; k < int'(n); k++) begin
            if (push_all || k == 0) ang_q.push_back(a);
            if (push_all) begin
                e.data = model(a, sc);
                e.idx  = AWB'(k);
                sb_q.push_back(e);
            end
            a = a + st;
        end
        i0 = n_init; o0 = n_out; init_k = 0; done_k = 0;
        @(posedge clk); #1;
        angle_start = as; angle_step = st; num_angles = n; x_scale = sc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (cordic_initiate && init_k == 0) init_k = k;
            if (done) begin done_k = k; break; end
        end
        err = error;
        ang_at_done = cordic_angle;
        @(negedge clk);
        after = done | busy;
        ninit = n_init - i0;
        nout  = n_out - o0;
    endtask

    vec_t vecs[5];

    initial begin
        int ik, dk, ni, no, bad;
        logic er, af, seen;
        logic [AWB-1:0] la;
        logic [RWB-1:0] ed;
        exp_t e;

        vecs[0] = '{as: 8'd0,   st: 8'd30,  n: 8'd4, sc: 23'd64,      last_angle: 8'd90};
        vecs[1] = '{as: 8'd250, st: 8'd10,  n: 8'd2, sc: 23'd100,     last_angle: 8'd4};
        vecs[2] = '{as: 8'd5,   st: 8'd1,   n: 8'd1, sc: 23'd1000,    last_angle: 8'd5};
        vecs[3] = '{as: 8'd17,  st: 8'd200, n: 8'd5, sc: 23'd12345,   last_angle: 8'd49};
        vecs[4] = '{as: 8'd128, st: 8'd128, n: 8'd3, sc: 23'd8388607, last_angle: 8'd128};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        angle_start = '0; angle_step = '0; num_angles = '0; x_scale = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, error, cordic_initiate, cordic_ack, out_valid,
                              out_index, cordic_angle, out_data, cordic_x_scale}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            resp_delay = i;
            drop_delay = i % 3;
            run_sweep(vecs[i].as, vecs[i].st, vecs[i].n, vecs[i].sc, 1'b1, ik, dk, ni, no, er, la, af);
            chk($sformatf("v%0d_done_seen", i), dk != 0, 1);
            chk($sformatf("v%0d_init_latency", i), ik, 2);
            chk($sformatf("v%0d_initiates", i), ni, vecs[i].n);
            chk($sformatf("v%0d_outputs", i), no, vecs[i].n);
            chk($sformatf("v%0d_error", i), er, 0);
            chk($sformatf("v%0d_last_angle", i), la, vecs[i].last_angle);
            chk($sformatf("v%0d_done_one_cycle", i), af, 0);
            chk($sformatf("v%0d_queues_empty", i), ang_q.size() + sb_q.size(), 0);
        end

        // Responder never answers: one request, then abort after the wait limit.
        resp_enable = 1'b0;
        run_sweep(8'd3, 8'd7, 8'd3, 23'd50, 1'b0, ik, dk, ni, no, er, la, af);
        chk("to_done_seen", dk != 0, 1);
        chk("to_initiates", ni, 1);
        chk("to_cycles", dk - ik, 255);
        chk("to_error", er, 1);
        chk("to_outputs", no, 0);
        chk("to_error_sticky", error, 1);
        resp_enable = 1'b1;
        ang_q.delete(); sb_q.delete();

        // Zero count also clears the sticky error.
        run_sweep(8'd9, 8'd9, 8'd0, 23'd1, 1'b1, ik, dk, ni, no, er, la, af);
        chk("zero_done_latency", dk, 1);
        chk("zero_initiates", ni, 0);
        chk("zero_outputs", no, 0);
        chk("zero_error_cleared", er, 0);

        // Downstream backpressure, with a start pulse that must be ignored.
        resp_delay = 1; drop_delay = 1;
        ed = model(8'd40, 23'd300);
        ang_q.push_back(8'd40);
        e.data = ed; e.idx = '0; sb_q.push_back(e);
        @(posedge clk); #1;
        out_ready = 1'b0; angle_start = 8'd40; angle_step = 8'd0; num_angles = 8'd1; x_scale = 23'd300; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("bp_valid_seen", seen, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start = (k == 2); num_angles = 8'd0;
            @(negedge clk);
            if (!(out_valid && out_data == ed && out_index == 0 && !cordic_ack)) bad++;
        end
        chk("bp_stall_stable", bad, 0);
        @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ack_not_yet", cordic_ack, 0);
        @(negedge clk);
        chk("bp_ack_next_cycle", cordic_ack, 1);
        chk("bp_valid_dropped", out_valid, 0);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk("bp_done_seen", seen, 1);
        chk("bp_queues_empty", ang_q.size() + sb_q.size(), 0);

        // Reset while the controller holds ack.
        resp_delay = 1; drop_delay = 6;
        run_reset_case(seen);
        chk("rst_ack_seen", seen, 1);
        chk("rst_outputs_zero", {busy, done, error, cordic_initiate, cordic_ack, out_valid,
                                 out_index, cordic_angle, out_data, cordic_x_scale}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        ang_q.delete(); sb_q.delete();
        drop_delay = 0;
        run_sweep(8'd3, 8'd4, 8'd2, 23'd9, 1'b1, ik, dk, ni, no, er, la, af);
        chk("rst_fresh_init_latency", ik, 2);
        chk("rst_fresh_initiates", ni, 2);
        chk("rst_fresh_outputs", no, 2);
        chk("rst_fresh_last_angle", la, 8'd7);
        chk("rst_fresh_error", er, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic run_reset_case(output logic seen);
        logic [AWB-1:0] a;
        exp_t e;
        a = 8'd10;
        for (int k = 0; k < 3; k++) begin
            ang_q.push_back(a);
            e.data = model(a, 23'd77); e.idx = AWB'(k);
            sb_q.push_back(e);
            a = a + 8'd5;
        end
        @(posedge clk); #1;
        angle_start = 8'd10; angle_step = 8'd5; num_angles = 8'd3; x_scale = 23'd77; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = cordic_ack;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

endmodule
